// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit and the control
// decoder that drives it: operand width, iteration count, op encodings and
// the unit's state encoding.
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int WIDTH = 32;              // only 32 is supported
    localparam int ITER  = WIDTH;           // one iteration per operand bit
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
// Bundle between the control unit / register file (master) and the
// multiply/divide unit (slave).
//   start, op        : launch an operation (op sampled with start)
//   src_a, src_b     : operands from register-file read ports A/B
//   mthi, mtlo       : direct writes of mt_data into HI/LO
//   busy, done       : operation in flight / one-cycle completion pulse
//   hi, lo           : HI/LO registers back to the write-data mux
// ---------------------------------------------------------------------------
interface muldiv_if;
    import muldiv_pkg::*;

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] mt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, mt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, mt_data,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative 32-bit multiply/divide unit owning HI/LO. A single shift-add /
// restoring-subtract datapath works on operand magnitudes for 32 cycles,
// then one fix-up cycle applies the result signs and writes HI/LO.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : muldiv_if.slave (start/op/src_a/src_b/mthi/mtlo/mt_data in,
//            busy/done/hi/lo out)
// ---------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic                  is_div;
    logic                  neg_q;     // product / quotient must be negated
    logic                  neg_r;     // remainder must be negated
    logic                  div0;
    logic [WIDTH-1:0]      mag_b;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]    acc;       // {partial, multiplier} or {rem, quot}
    logic [2*WIDTH-1:0]    acc_next;
    logic                  busy_q;
    logic                  done_q;
    logic [WIDTH-1:0]      hi_q;
    logic [WIDTH-1:0]      lo_q;

    // Start-cycle decode of the incoming operation.
    op_e              op_in;
    logic             signed_op;
    logic             div_op;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;

    assign op_in     = op_e'(bus.op);
    assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign div_op    = (op_in == OP_DIV)  || (op_in == OP_DIVU);
    // 32'h8000_0000 wraps to itself, which is exactly the magnitude we want
    // when it is treated as unsigned.
    assign mag_a_in  = (signed_op && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    assign mag_b_in  = (signed_op && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

    // One iteration of either algorithm.
    logic [WIDTH:0]   sum;
    logic             ge;
    logic [WIDTH-1:0] rem_sub;

    always_comb begin
        // NOTE: every variable gets a value on every path so no latch is inferred.
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & mag_b};
        // Shifted remainder is 33 bits; the difference always fits 32 bits
        // whenever it is kept.
        ge       = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, mag_b};
        rem_sub  = acc[2*WIDTH-2:WIDTH-1] - mag_b;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            acc_next = ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                          : {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction applied in the fix-up cycle.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = neg_q ? -acc : acc;
    assign quot_fix = div0  ? {WIDTH{1'b1}}
                    : neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // With a zero divisor the remainder is the dividend magnitude, so
    // re-applying the dividend sign reproduces the original src_a.
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            mag_b  <= '0;
            acc    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        // start wins over any same-cycle mthi/mtlo
                        state  <= S_RUN;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        is_div <= div_op;
                        neg_q  <= signed_op && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                        neg_r  <= signed_op && bus.src_a[WIDTH-1];
                        div0   <= div_op && (bus.src_b == '0);
                        mag_b  <= mag_b_in;
                        acc    <= {{WIDTH{1'b0}}, mag_a_in};
                    end else begin
                        if (bus.mthi) hi_q <= bus.mt_data;
                        if (bus.mtlo) lo_q <= bus.mt_data;
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: directed corner cases, handshake and
// MTHI/MTLO behaviour, mid-operation reset, then randomized operations, all
// compared against an arithmetic reference model and a model of HI/LO.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int LATENCY = 34;    // start cycle to done cycle
    localparam int LIMIT   = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    // Reference result {hi, lo} straight from the arithmetic definition.
    function automatic logic [63:0] ref_result(input logic [1:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT:  p = 64'(sa * sb);
            OP_MULTU: p = {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) begin
                    q = 32'hFFFF_FFFF; r = a;
                end else begin
                    q = 32'(sa / sb); r = 32'(sa % sb);
                end
                p = {r, q};
            end
            default: begin
                if (b == 0) begin
                    q = 32'hFFFF_FFFF; r = a;
                end else begin
                    q = a / b; r = a % b;
                end
                p = {r, q};
            end
        endcase
        return p;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle start; returns at the negedge of cycle 1.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.src_a = $urandom;
        bus.src_b = $urandom;
    endtask

    // Waits for done starting from cycle 'from'; checks latency, result,
    // busy, and that done is a single pulse with HI/LO held afterwards.
    task automatic finish_op(input string tag, input logic [1:0] o,
                             input logic [31:0] a, input logic [31:0] b, input int from);
        int          cyc;
        logic [63:0] res;
        cyc = from;
        while (bus.done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        res = ref_result(o, a, b);
        check_int({tag, "_latency"}, cyc, LATENCY);
        check32({tag, "_hi"}, bus.hi, res[63:32]);
        check32({tag, "_lo"}, bus.lo, res[31:0]);
        check32({tag, "_busy"}, 32'(bus.busy), 32'd0);
        m_hi = res[63:32];
        m_lo = res[31:0];
        @(negedge clk);
        check32({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check32({tag, "_hi_hold"}, bus.hi, m_hi);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        start_op(o, a, b);
        check32({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
        finish_op(tag, o, a, b, 1);
    endtask

    task automatic count_dones(input int n, output int k);
        k = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done === 1'b1) k++;
        end
    endtask

    initial begin
        logic [31:0] a, b, d;
        logic [1:0]  o;
        int          k;

        bus.start   = 1'b0;
        bus.op      = '0;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.mt_data = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check32("reset_busy", 32'(bus.busy), 32'd0);
        check32("reset_done", 32'(bus.done), 32'd0);
        check32("reset_hi", bus.hi, 32'd0);
        check32("reset_lo", bus.lo, 32'd0);
        rst_n = 1'b1;

        // Directed corner cases
        run_op("mult_7_m3",     OP_MULT,  32'h0000_0007, 32'hFFFF_FFFD);
        run_op("multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_m1_m1",    OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
        run_op("divu_7_2",      OP_DIVU,  32'h0000_0007, 32'h0000_0002);
        run_op("div_5_0",       OP_DIV,   32'h0000_0005, 32'h0000_0000);
        run_op("div_min_m1",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_m5_0",      OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000);
        run_op("divu_big_0",    OP_DIVU,  32'hDEAD_BEEF, 32'h0000_0000);

        // Second start in cycle 5 is ignored
        a = $urandom; b = $urandom;
        start_op(OP_MULTU, a, b);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        finish_op("ignored_start", OP_MULTU, a, b, 6);
        count_dones(40, k);
        check_int("ignored_start_extra_done", k, 0);

        // mthi while busy is ignored
        a = $urandom; b = $urandom_range(1, 1000);
        start_op(OP_DIVU, a, b);
        @(negedge clk);
        bus.mthi    = 1'b1;
        bus.mt_data = ~m_hi;
        @(negedge clk);
        bus.mthi    = 1'b0;
        check32("mthi_busy_hi", bus.hi, m_hi);
        finish_op("mthi_busy_op", OP_DIVU, a, b, 3);

        // mtlo in IDLE, then both together
        @(negedge clk);
        bus.mtlo    = 1'b1;
        bus.mt_data = 32'h1234_5678;
        @(negedge clk);
        bus.mtlo    = 1'b0;
        check32("mtlo_lo", bus.lo, 32'h1234_5678);
        check32("mtlo_hi_kept", bus.hi, m_hi);
        m_lo = 32'h1234_5678;
        d = $urandom;
        bus.mthi    = 1'b1;
        bus.mtlo    = 1'b1;
        bus.mt_data = d;
        @(negedge clk);
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        check32("mt_both_hi", bus.hi, d);
        check32("mt_both_lo", bus.lo, d);
        m_hi = d;
        m_lo = d;

        // start and mthi in the same IDLE cycle: mthi dropped
        a = $urandom; b = $urandom;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = OP_MULT;
        bus.src_a   = a;
        bus.src_b   = b;
        bus.mthi    = 1'b1;
        bus.mt_data = ~m_hi;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.mthi    = 1'b0;
        check32("start_mthi_hi", bus.hi, m_hi);
        finish_op("start_mthi_op", OP_MULT, a, b, 1);

        // Reset in cycle 10 of a DIV
        start_op(OP_DIV, $urandom, $urandom_range(1, 50));
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check32("midreset_busy", 32'(bus.busy), 32'd0);
        check32("midreset_hi", bus.hi, 32'd0);
        check32("midreset_lo", bus.lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        count_dones(40, k);
        check_int("midreset_no_done", k, 0);
        run_op("after_reset", OP_DIV, 32'hFFFF_FF00, 32'h0000_0007);

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", o, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
